// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for the execute stage.
// Multiply is radix-2 shift-add and divide is restoring, both one bit per
// cycle on operand magnitudes, with the sign fix-up in a final CALC cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in a
// single cycle. Results return to writeback through a valid/ready handshake.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_fn,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched operation. acc holds {partial, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; opb is the multiplicand or
    // divisor magnitude.
    logic [2:0]        fn_q;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              last;      // all XLEN iterations done; next CALC cycle finalises
    logic              res_neg;   // product / quotient must be negated
    logic              rem_neg;   // dividend was negative, remainder follows it

    // request decode
    logic            accept;
    logic            is_div;
    logic            rs1_sgn;
    logic            rs2_sgn;
    logic            neg1;
    logic            neg2;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN-1:0] spec_data;

    // iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_dif;
    logic              div_ge;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] step_nxt;

    // sign fix-up and result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin_data;

    // req_ready depends on state only, so there is no input-to-output path
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    assign accept = req_valid & req_ready & ~flush;
    assign is_div = req_fn[2];

    // Operand signedness from funct3: MULH/DIV/REM signed both, MULHSU rs1 only
    always_comb begin
        rs1_sgn = 1'b0;
        rs2_sgn = 1'b0;
        case (req_fn)
            3'b001, 3'b100, 3'b110: begin
                rs1_sgn = 1'b1;
                rs2_sgn = 1'b1;
            end
            3'b010:  rs1_sgn = 1'b1;
            default: ;
        endcase
    end

    assign neg1 = rs1_sgn & rs1_data[XLEN-1];
    assign neg2 = rs2_sgn & rs2_data[XLEN-1];
    assign mag1 = neg1 ? (~rs1_data + XLEN'(1)) : rs1_data;
    assign mag2 = neg2 ? (~rs2_data + XLEN'(1)) : rs2_data;

    // Overflow only exists for the signed divide pair (funct3 bit0 clear)
    assign div_zero = is_div & (rs2_data == '0);
    assign div_ovf  = is_div & ~req_fn[0] & (rs1_data == MIN_NEG) & (rs2_data == ONES);
    assign special  = div_zero | div_ovf;

    // Architecturally defined results for the divide corner cases; bit1 picks REM*
    always_comb begin
        spec_data = ONES;
        if (div_zero)
            spec_data = req_fn[1] ? rs1_data : ONES;
        else if (div_ovf)
            spec_data = req_fn[1] ? '0 : rs1_data;
    end

    // One shift-add or restoring-subtract step on the accumulator
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt  = {mul_sum, acc[XLEN-1:1]};
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        div_dif  = div_sh - {1'b0, opb};
        div_nxt  = {(div_ge ? div_dif[XLEN-1:0] : div_sh[XLEN-1:0]),
                    acc[XLEN-2:0], div_ge};
        step_nxt = fn_q[2] ? div_nxt : mul_nxt;
    end

    assign prod = res_neg ? (~acc + (2*XLEN)'(1)) : acc;
    assign quo  = res_neg ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    assign rem  = rem_neg ? (~acc[2*XLEN-1:XLEN] + XLEN'(1)) : acc[2*XLEN-1:XLEN];

    // Select the architectural result for the latched operation
    always_comb begin
        fin_data = prod[XLEN-1:0];
        case (fn_q)
            3'b000:                 fin_data = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_data = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_data = quo;
            default:                fin_data = rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: flush beats the response handshake in CALC and DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = special ? DONE : CALC;
            end
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                if (flush || resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fn_q      <= '0;
            opb       <= '0;
            acc       <= '0;
            cnt       <= '0;
            last      <= 1'b0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fn_q    <= req_fn;
                        res_neg <= neg1 ^ neg2;
                        rem_neg <= neg1;
                        cnt     <= CNT_W'(XLEN-1);
                        last    <= 1'b0;
                        if (is_div) begin
                            opb <= mag2;
                            acc <= {{XLEN{1'b0}}, mag1};
                        end else begin
                            opb <= mag1;
                            acc <= {{XLEN{1'b0}}, mag2};
                        end
                        if (special)
                            resp_data <= spec_data;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        if (last) begin
                            resp_data <= fin_data;
                        end else begin
                            acc <= step_nxt;
                            if (cnt == '0)
                                last <= 1'b1;
                            else
                                cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table, hand sequences for backpressure,
// flush and reset, and random operations against an arithmetic model.
module tb_mul_div_unit;

    localparam int XLEN = 32;
    localparam int LAT_NORM = XLEN + 1;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_fn;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    int errors = 0;
    int checks = 0;
    logic busy_ok;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fn     (req_fn),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [2:0] fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics using wide host arithmetic
    function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (fn)
            3'd0: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * longint'(ub);
            3'd3: p = ua * ub;
            3'd4: begin
                if (b == 0) p = 64'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'd0, a};
                else p = sa / sb;
            end
            3'd5: p = (b == 0) ? 64'hFFFFFFFF : ua / ub;
            3'd6: begin
                if (b == 0) p = {32'd0, a};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = 64'd0;
                else p = sa % sb;
            end
            default: p = (b == 0) ? {32'd0, a} : ua % ub;
        endcase
        if (fn == 3'd1 || fn == 3'd2 || fn == 3'd3)
            return p[63:32];
        return p[31:0];
    endfunction

    function automatic int model_lat(input logic [2:0] fn, input logic [31:0] a,
                                     input logic [31:0] b);
        if (fn[2] && (b == 0 || (!fn[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return LAT_NORM;
    endfunction

    // Present a request until the accepting edge; returns #1 after that edge
    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        req_fn    = fn;
        rs1_data  = a;
        rs2_data  = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count edges from accept until resp_valid; -1 on timeout
    task automatic wait_valid(output int lat);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat);
        issue(fn, a, b);
        wait_valid(lat);
        data = resp_data;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    vec_t vt[12];

    initial begin
        logic [31:0] d;
        logic [31:0] held;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        int lat;
        bit saw;

        vt[0]  = '{"mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_NORM};
        vt[1]  = '{"mulh_min_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT_NORM};
        vt[2]  = '{"mulhu_ones",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORM};
        vt[3]  = '{"mulhsu_ones",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_NORM};
        vt[4]  = '{"div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_NORM};
        vt[5]  = '{"rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_NORM};
        vt[6]  = '{"divu_7_2",     3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, LAT_NORM};
        vt[7]  = '{"remu_7_2",     3'd7, 32'hFFFFFFF9, 32'd2,        32'd1,        LAT_NORM};
        vt[8]  = '{"div_by0",      3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vt[9]  = '{"remu_by0",     3'd7, 32'd5,        32'd0,        32'd5,        1};
        vt[10] = '{"div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vt[11] = '{"rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

        rst_n = 1'b0; req_valid = 1'b0; req_fn = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; resp_ready = 1'b0;
        #12;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data",  resp_data,  0);
        chk("rst_busy",       busy,       0);
        chk("rst_req_ready",  req_ready,  1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed table
        foreach (vt[i]) begin
            run_op(vt[i].fn, vt[i].a, vt[i].b, d, lat);
            chk({vt[i].name, "_data"}, d, vt[i].exp);
            chk({vt[i].name, "_lat"}, lat, vt[i].lat);
            if (vt[i].lat != 1) chk({vt[i].name, "_busy"}, busy_ok, 1);
            chk({vt[i].name, "_held"}, resp_data, vt[i].exp);
            chk({vt[i].name, "_drop"}, resp_valid, 0);
        end

        // backpressure: result held, no acceptance while DONE
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(lat);
        chk("bp_lat", lat, LAT_NORM);
        held = resp_data;
        chk("bp_data", held, 32'hFFFFFFFE);
        req_valid = 1'b1; req_fn = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", resp_valid, 1);
            chk("bp_data_hold", resp_data, held);
            chk("bp_ready_low", req_ready, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_ready_back", req_ready, 1);
        chk("bp_valid_drop", resp_valid, 0);
        chk("bp_data_keep", resp_data, held);
        @(posedge clk); #1;
        chk("bp_no_accept", busy, 0);

        // flush at cycle 10 of CALC
        issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_req_ready", req_ready, 1);
        chk("fl_valid", resp_valid, 0);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) saw = 1'b1;
        end
        chk("fl_no_resp", saw, 0);
        run_op(3'd3, 32'd3, 32'd5, d, lat);
        chk("fl_mulhu_3_5", d, 0);
        chk("fl_mulhu_lat", lat, LAT_NORM);

        // flush in IDLE blocks acceptance
        req_valid = 1'b1; req_fn = 3'd0; rs1_data = 32'd2; rs2_data = 32'd3; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_block", busy, 0);

        // flush in DONE beats the handshake
        issue(3'd4, 32'd5, 32'd0);
        chk("fl_done_valid", resp_valid, 1);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; resp_ready = 1'b0;
        chk("fl_done_drop", resp_valid, 0);
        chk("fl_done_idle", req_ready, 1);

        // asynchronous reset mid-CALC
        issue(3'd0, 32'd100, 32'd200);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", resp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_data", resp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 32'd100, 32'd200, d, lat);
        chk("rst_recover", d, 32'd20000);

        // random operations against the model
        for (int n = 0; n < 60; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                2:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(rf, ra, rb, d, lat);
            chk($sformatf("rnd%0d_fn%0d_%h_%h", n, rf, ra, rb), d, model(rf, ra, rb));
            chk($sformatf("rnd%0d_lat", n), lat, model_lat(rf, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
